// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the signals between the byte producers, the arbiter and the single
// uart_tx instance.
//
// Handshake: req[i] is a level request. Once raised, req[i] and its byte in
// req_data[8i+7:8i] stay stable until ack[i] pulses for one cycle. In the cycle
// after ack[i] the producer either drops req[i] or presents its next byte.
// tx_start is a one-cycle pulse to the transmitter, and tx_data is stable in
// that cycle. tx_ready is high while the transmitter is idle.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   IDW      width of grant_id, equal to clog2(NREQ) and at least 1
// Signals:
//   req       requests from the producers
//   req_data  flattened bytes, 8 bits per requester
//   ack       one-hot capture pulse back to the producers
//   tx_start  start pulse to uart_tx
//   tx_data   byte to uart_tx
//   tx_ready  idle indication from uart_tx
//   busy      high while a granted character is in flight
//   grant_id  index of the last granted requester
// Modports:
//   slave   arbiter side
//   master  producer / transmitter side
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              busy;
  logic [IDW-1:0]    grant_id;

  modport slave (
    input  req, req_data, tx_ready,
    output ack, tx_start, tx_data, busy, grant_id
  );

  modport master (
    output req, req_data, tx_ready,
    input  ack, tx_start, tx_data, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx transmitter between NREQ byte producers. The block grants
// one requester per character, drives start/data to the transmitter, and
// follows tx_ready through its low period so that characters never overlap.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   io_bus       uart_tx_arbiter_if.slave (req, req_data, tx_ready in;
//                ack, tx_start, tx_data, busy, grant_id out)
//   o_dbg_state  current FSM state (0 IDLE, 1 WAIT_BUSY, 2 WAIT_DONE)
//
// Build option:
//   UART_TX_ARB_FIXED_PRIO_EN  When this macro is defined, the lowest requesting
//                              index always wins. When it is undefined, selection
//                              is round-robin, starting after grant_id.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  uart_tx_arbiter_if.slave     io_bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  localparam logic [IDW-1:0] LP_LAST_ID = IDW'(NREQ - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   w_ack_nxt;
  logic              r_tx_start;
  logic              w_tx_start_nxt;
  logic [7:0]        r_tx_data;
  logic [7:0]        w_tx_data_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic [IDW-1:0]    r_grant_id;
  logic [IDW-1:0]    w_grant_id_nxt;

  logic              w_win_vld;
  logic [IDW-1:0]    w_win;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top down so that the lowest index set wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (io_bus.req[i]) begin
        w_win_vld = 1'b1;
        w_win     = IDW'(i);
      end
    end
  end
`else
  localparam logic [IDW:0] LP_NREQ = (IDW + 1)'(NREQ);

  // Round-robin: grant_id doubles as the pointer. Offsets 1..NREQ visit every
  // index once, and the index that was just served comes last. The extra sum
  // bit keeps the wrap correct when NREQ is not a power of two.
  always_comb begin : rr_sel
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    w_win_vld = 1'b0;
    w_win     = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_grant_id} + (IDW + 1)'(k);
      if (w_sum >= LP_NREQ) begin
        w_sum = w_sum - LP_NREQ;
      end
      w_idx = IDW'(w_sum);
      if (!w_win_vld && io_bus.req[w_idx]) begin
        w_win_vld = 1'b1;
        w_win     = w_idx;
      end
    end
  end
`endif

  // Next-state and registered-output logic. ack and tx_start default to 0,
  // so each of them is high for only the one cycle after a grant.
  always_comb begin
    w_state_nxt    = r_state;
    w_ack_nxt      = '0;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
    w_busy_nxt     = r_busy;
    w_grant_id_nxt = r_grant_id;
    case (r_state)
      S_IDLE: begin
        if (io_bus.tx_ready && w_win_vld) begin
          w_ack_nxt      = {{(NREQ - 1){1'b0}}, 1'b1} << w_win;
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = io_bus.req_data[{w_win, 3'b000} +: 8];
          w_grant_id_nxt = w_win;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_WAIT_BUSY;
        end
      end
      // The FSM waits for the transmitter to take the character (ready falls)
      // and then for it to finish (ready rises). No new grant is possible
      // until ready rises again.
      S_WAIT_BUSY: begin
        if (!io_bus.tx_ready) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (io_bus.tx_ready) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_ack      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_grant_id <= LP_LAST_ID;
    end else begin
      r_state    <= w_state_nxt;
      r_ack      <= w_ack_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_busy     <= w_busy_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

  assign io_bus.ack      = r_ack;
  assign io_bus.tx_start = r_tx_start;
  assign io_bus.tx_data  = r_tx_data;
  assign io_bus.busy     = r_busy;
  assign io_bus.grant_id = r_grant_id;
  assign o_dbg_state     = r_state;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` transmitter between `NREQ` byte producers (echo path, status reporter, debug dumper, …). Requesters post a byte with a level request. The block grants one requester per character in round-robin order, drives the transmitter's `start`/`data`, and tracks `ready` so that no character is lost or overlapped. It sits between the producers and the single `uart_tx` instance at the top level.

## Interface
- `NREQ`, 4: number of requesters, legal 2..8.
- `IDW`, 2: width of `grant_id`; must equal clog2(`NREQ`), minimum 1.
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `req`  in  `NREQ`  per-requester request level. Held high with data stable until `ack`.
- `req_data`  in  8*`NREQ`  flattened bytes; requester i uses bits [8i+7:8i].
- `ack`  out  `NREQ`  one-hot, one-cycle pulse: requester i's byte has been captured.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx`; held stable until the next grant.
- `tx_ready`  in  1  `uart_tx` ready: high when idle, low while sending.
- `busy`  out  1  high from grant until `tx_ready` returns high.
- `grant_id`  out  `IDW`  index of the last granted requester.

## Operation
- All outputs are registered.
- Reset values: `ack`=0, `tx_start`=0, `tx_data`=0, `busy`=0, `grant_id`=`NREQ`-1. The round-robin pointer equals `grant_id`, so requester 0 wins first after reset.
- FSM has three states:
  - IDLE: if `tx_ready`=1 and `req`≠0, select a winner w and register `ack[w]`=1, `tx_start`=1, `tx_data`=byte w, `grant_id`=w, `busy`=1, then go to WAIT_BUSY. If `tx_ready`=0 or `req`=0, stay in IDLE.
  - WAIT_BUSY: `ack` and `tx_start` return to 0. On `tx_ready`=0, go to WAIT_DONE. Otherwise stay.
  - WAIT_DONE: on `tx_ready`=1, clear `busy` and go to IDLE.
- Round-robin selection: search indices `grant_id`+1, +2, … modulo `NREQ`. The first index with its `req` bit high wins.
- Requests are sampled only in IDLE. `req` changes in other states are ignored, and nothing is queued.
- A requester must drop `req` or present its next byte in the cycle after `ack`. The FSM is out of IDLE for at least 2 cycles after a grant, so one request is never accepted twice.
- A request withdrawn before grant is simply not served. No error is raised.
- Reset asserted mid-character: all outputs return to reset values immediately and the FSM enters IDLE. The `uart_tx` instance shares `rstn` and aborts its frame too.

## Timing
- Grant latency: a request valid in IDLE at edge k produces `ack`, `tx_start` and `tx_data` valid in the cycle after edge k, which is 1 cycle.
- `tx_start` is exactly one cycle wide, and `tx_data` is already stable in that cycle.
- Back-to-back characters: the next grant occurs in the cycle after `tx_ready` rises, plus 1 cycle of IDLE evaluation.
- At most one `ack` bit is high in any cycle. At most one `tx_start` is issued per `tx_ready` low period.

## Configuration
- `UART_TX_ARB_FIXED_PRIO_EN`
  - Undefined (default): round-robin selection as described above.
  - Defined: fixed priority, where the lowest index with `req` high always wins. `grant_id` still reports the winner, but the pointer has no effect on selection.

## Test plan
- Single request: after reset, `req`=4'b0100 with byte 8'h41. Expect `ack`=4'b0100 and `tx_start`=1 for one cycle, `tx_data`=8'h41, `grant_id`=2, and `busy` high until `tx_ready` rises.
- Round robin: all four `req` held high, each dropped after its `ack`. Expect grant order 0,1,2,3. Re-raise all four: order 0,1,2,3 again. With the macro defined, expect 0 wins every time all four are high.
- Fairness: `req[0]` and `req[3]` held high continuously, with a new byte presented after each `ack`. Grants must alternate 0,3,0,3.
- Transmitter busy: `tx_ready`=0 at the time `req`=4'b0001 arrives. Expect no `ack` and no `tx_start` until `tx_ready`=1, then a grant 1 cycle later.
- Reset mid-frame: assert `rstn`=0 during WAIT_DONE. Expect `busy`=0, `tx_start`=0, `grant_id`=3 immediately. After release, a pending `req`=4'b1111 grants 0 first.
- Loopback with real `uart_tx` at 115200 baud: requesters send 8'h55 and 8'hAA. Expect both bytes on `tx` in grant order with correct framing and no overlap.
